// File: rtl/ifetch_prefetch_buffer.sv
// ifetch_prefetch_buffer
// Instruction prefetch buffer between a 1-cycle-latency synchronous
// instruction memory and the CPU fetch stage. A sequential fetch PC runs
// ahead of the core and issues one word read per cycle while credit allows.
// Returned words queue in a small FIFO and are presented with valid/ready.
// A redirect flushes the queue, drops the in-flight word and restarts fetch.
//
// Optional feature: define IFETCH_BYPASS_EN to present a returning word
// directly to fetch when the FIFO is empty (1-cycle fetch latency).
//
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   redirect_i            flush and restart at redirect_addr_i (bits [1:0] ignored)
//   mem_en_o, mem_addr_o  read request to instruction memory
//   mem_dout_i            memory data, valid the cycle after mem_en_o
//   instr_valid_o, instr_o, instr_pc_o, instr_ready_i   fetch handshake
//   count_o               FIFO occupancy
module ifetch_prefetch_buffer #(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         redirect_i,
    input  logic [ADDR_W-1:0]            redirect_addr_i,
    output logic                         mem_en_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic [DATA_W-1:0]            mem_dout_i,
    output logic                         instr_valid_o,
    output logic [DATA_W-1:0]            instr_o,
    output logic [ADDR_W-1:0]            instr_pc_o,
    input  logic                         instr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] pf_pc_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic              credit_ok;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              fifo_valid;
    logic              bypass;
    logic              push;
    logic              pop;

    // Outstanding words (queued + in flight) must never exceed DEPTH, which
    // guarantees every return has a slot without looking at pops.
    assign credit_ok  = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH);
    // Gating with rst_ni keeps the request low while reset is asserted.
    assign issue      = rst_ni & (redirect_i | credit_ok);
    assign issue_addr = redirect_i ? {redirect_addr_i[ADDR_W-1:2], 2'b00} : pf_pc_q;

    assign mem_en_o   = issue;
    assign mem_addr_o = issue_addr;

    assign fifo_valid = (count_q != '0) & ~redirect_i;
    assign pop        = fifo_valid & instr_ready_i;

`ifdef IFETCH_BYPASS_EN
    assign bypass        = inflight_q & (count_q == '0) & ~redirect_i;
    assign instr_valid_o = fifo_valid | bypass;
    assign instr_o       = bypass ? mem_dout_i    : fifo_data[rd_ptr_q];
    assign instr_pc_o    = bypass ? inflight_pc_q : fifo_pc[rd_ptr_q];
`else
    assign bypass        = 1'b0;
    assign instr_valid_o = fifo_valid;
    assign instr_o       = fifo_data[rd_ptr_q];
    assign instr_pc_o    = fifo_pc[rd_ptr_q];
`endif

    // A bypassed word that fetch accepts is consumed and never queued.
    assign push    = inflight_q & ~redirect_i & ~(bypass & instr_ready_i);
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pf_pc_q       <= RESET_ADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pf_pc_q       <= issue_addr + ADDR_W'(4);
                inflight_pc_q <= issue_addr;
            end
            if (redirect_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    fifo_data[wr_ptr_q] <= mem_dout_i;
                    fifo_pc[wr_ptr_q]   <= inflight_pc_q;
                    wr_ptr_q            <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
module tb_ifetch_prefetch_buffer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = 3;
`ifdef IFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic              clk_i;
    logic              rst_ni;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_addr_i;
    logic              mem_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_dout_i;
    logic              instr_valid_o;
    logic [DATA_W-1:0] instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_ready_i;
    logic [CW-1:0]     count_o;

    int n_pass  = 0;
    int n_total = 0;

    ifetch_prefetch_buffer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_ADDR('0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_dout_i(mem_dout_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i), .count_o(count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // memory word k (byte address 4k) holds 0x10000000 + k
    function automatic logic [DATA_W-1:0] word_at(input int a);
        return 32'h1000_0000 + DATA_W'(a >> 2);
    endfunction

    always @(posedge clk_i) begin
        if (mem_en_o) mem_dout_i <= word_at(int'(mem_addr_o));
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic apply_reset(input logic rdy);
        rst_ni          = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        instr_ready_i   = rdy;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0; instr_ready_i = 1'b1;
        @(negedge clk_i); #1;
        n_total++; if (mem_en_o !== 1'b0) $display("FAIL reset_en got=%b exp=0", mem_en_o); else n_pass++;
        n_total++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid_o); else n_pass++;
        n_total++; if (count_o !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count_o); else n_pass++;
        n_total++; if (instr_o !== 32'd0) $display("FAIL reset_instr got=%h exp=0", instr_o); else n_pass++;
        n_total++; if (instr_pc_o !== 10'd0) $display("FAIL reset_pc got=%h exp=0", instr_pc_o); else n_pass++;
    endtask

    task automatic test_stream();
        apply_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            n_total++; if (mem_en_o !== 1'b1) $display("FAIL stream_en k=%0d got=%b exp=1", k, mem_en_o); else n_pass++;
            n_total++; if (mem_addr_o !== 10'(4*k)) $display("FAIL stream_addr k=%0d got=%h exp=%h", k, mem_addr_o, 10'(4*k)); else n_pass++;
            n_total++; if (instr_valid_o !== (k >= LAT)) $display("FAIL stream_valid k=%0d got=%b exp=%b", k, instr_valid_o, (k >= LAT)); else n_pass++;
            if (k >= LAT) begin
                n_total++; if (instr_pc_o !== 10'(4*(k-LAT))) $display("FAIL stream_pc k=%0d got=%h exp=%h", k, instr_pc_o, 10'(4*(k-LAT))); else n_pass++;
                n_total++; if (instr_o !== word_at(4*(k-LAT))) $display("FAIL stream_data k=%0d got=%h exp=%h", k, instr_o, word_at(4*(k-LAT))); else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int issues;
        issues = 0;
        apply_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            if (mem_en_o === 1'b1) begin
                n_total++; if (mem_addr_o !== 10'(4*issues)) $display("FAIL bp_addr got=%h exp=%h", mem_addr_o, 10'(4*issues)); else n_pass++;
                issues++;
            end
            step();
        end
        n_total++; if (issues != 4) $display("FAIL bp_issues got=%0d exp=4", issues); else n_pass++;
        n_total++; if (count_o !== 3'd4) $display("FAIL bp_count got=%0d exp=4", count_o); else n_pass++;
        n_total++; if (mem_en_o !== 1'b0) $display("FAIL bp_en_full got=%b exp=0", mem_en_o); else n_pass++;
        instr_ready_i = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            n_total++; if (instr_valid_o !== 1'b1) $display("FAIL bp_drain_valid i=%0d got=%b exp=1", i, instr_valid_o); else n_pass++;
            n_total++; if (instr_pc_o !== 10'(4*i)) $display("FAIL bp_drain_pc i=%0d got=%h exp=%h", i, instr_pc_o, 10'(4*i)); else n_pass++;
            n_total++; if (instr_o !== word_at(4*i)) $display("FAIL bp_drain_data i=%0d got=%h exp=%h", i, instr_o, word_at(4*i)); else n_pass++;
            step();
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        repeat (4) step();
        n_total++; if (count_o !== 3'd3) $display("FAIL redir_pre_count got=%0d exp=3", count_o); else n_pass++;
        redirect_i = 1'b1; redirect_addr_i = 10'h042;
        #1;
        n_total++; if (instr_valid_o !== 1'b0) $display("FAIL redir_valid got=%b exp=0", instr_valid_o); else n_pass++;
        n_total++; if (mem_en_o !== 1'b1) $display("FAIL redir_en got=%b exp=1", mem_en_o); else n_pass++;
        n_total++; if (mem_addr_o !== 10'h040) $display("FAIL redir_addr got=%h exp=040", mem_addr_o); else n_pass++;
        step();
        redirect_i = 1'b0;
        #1;
        n_total++; if (count_o !== 3'd0) $display("FAIL redir_count got=%0d exp=0", count_o); else n_pass++;
        n_total++; if (instr_valid_o !== (LAT == 1)) $display("FAIL redir_valid_n1 got=%b exp=%b", instr_valid_o, (LAT == 1)); else n_pass++;
        step();
        n_total++; if (instr_valid_o !== 1'b1) $display("FAIL redir_valid_n2 got=%b exp=1", instr_valid_o); else n_pass++;
        n_total++; if (instr_pc_o !== 10'h040) $display("FAIL redir_pc got=%h exp=040", instr_pc_o); else n_pass++;
        n_total++; if (instr_o !== 32'h1000_0010) $display("FAIL redir_data got=%h exp=10000010", instr_o); else n_pass++;
        instr_ready_i = 1'b1;
        step();
        n_total++; if (instr_pc_o !== 10'h044) $display("FAIL redir_next_pc got=%h exp=044", instr_pc_o); else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset(1'b1);
        repeat (3) step();
        redirect_i = 1'b1; redirect_addr_i = 10'h3FE;
        #1;
        n_total++; if (mem_addr_o !== 10'h3FC) $display("FAIL wrap_issue got=%h exp=3fc", mem_addr_o); else n_pass++;
        step();
        redirect_i = 1'b0;
        #1;
        n_total++; if (mem_addr_o !== 10'h000) $display("FAIL wrap_next_addr got=%h exp=000", mem_addr_o); else n_pass++;
        for (int j = 1; j < LAT; j++) step();
        n_total++; if (instr_valid_o !== 1'b1) $display("FAIL wrap_valid got=%b exp=1", instr_valid_o); else n_pass++;
        n_total++; if (instr_pc_o !== 10'h3FC) $display("FAIL wrap_pc0 got=%h exp=3fc", instr_pc_o); else n_pass++;
        n_total++; if (instr_o !== 32'h1000_00FF) $display("FAIL wrap_data0 got=%h exp=100000ff", instr_o); else n_pass++;
        step();
        n_total++; if (instr_pc_o !== 10'h000) $display("FAIL wrap_pc1 got=%h exp=000", instr_pc_o); else n_pass++;
        n_total++; if (instr_o !== 32'h1000_0000) $display("FAIL wrap_data1 got=%h exp=10000000", instr_o); else n_pass++;
    endtask

    task automatic test_bypass();
        apply_reset(1'b1);
        redirect_i = 1'b1; redirect_addr_i = 10'h100;
        #1;
        n_total++; if (mem_addr_o !== 10'h100) $display("FAIL byp_addr got=%h exp=100", mem_addr_o); else n_pass++;
        step();
        redirect_i = 1'b0;
        #1;
        n_total++; if (instr_valid_o !== (LAT == 1)) $display("FAIL byp_valid_n1 got=%b exp=%b", instr_valid_o, (LAT == 1)); else n_pass++;
        n_total++; if (count_o !== 3'd0) $display("FAIL byp_count got=%0d exp=0", count_o); else n_pass++;
        step();
        n_total++; if (instr_valid_o !== 1'b1) $display("FAIL byp_valid_n2 got=%b exp=1", instr_valid_o); else n_pass++;
        n_total++; if (instr_pc_o !== ((LAT == 1) ? 10'h104 : 10'h100)) $display("FAIL byp_pc_n2 got=%h exp=%h", instr_pc_o, ((LAT == 1) ? 10'h104 : 10'h100)); else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset(1'b0);
        repeat (6) step();
        n_total++; if (count_o !== 3'd4) $display("FAIL ares_pre_count got=%0d exp=4", count_o); else n_pass++;
        n_total++; if (instr_valid_o !== 1'b1) $display("FAIL ares_pre_valid got=%b exp=1", instr_valid_o); else n_pass++;
        #2;
        rst_ni = 1'b0;
        #1;
        n_total++; if (instr_valid_o !== 1'b0) $display("FAIL ares_valid got=%b exp=0", instr_valid_o); else n_pass++;
        n_total++; if (mem_en_o !== 1'b0) $display("FAIL ares_en got=%b exp=0", mem_en_o); else n_pass++;
        n_total++; if (count_o !== 3'd0) $display("FAIL ares_count got=%0d exp=0", count_o); else n_pass++;
        n_total++; if (instr_o !== 32'd0) $display("FAIL ares_instr got=%h exp=0", instr_o); else n_pass++;
        @(negedge clk_i);
        instr_ready_i = 1'b1;
        rst_ni = 1'b1;
        #1;
        n_total++; if (mem_en_o !== 1'b1) $display("FAIL ares_restart_en got=%b exp=1", mem_en_o); else n_pass++;
        n_total++; if (mem_addr_o !== 10'h000) $display("FAIL ares_restart_addr got=%h exp=000", mem_addr_o); else n_pass++;
        repeat (LAT) step();
        n_total++; if (instr_valid_o !== 1'b1) $display("FAIL ares_first_valid got=%b exp=1", instr_valid_o); else n_pass++;
        n_total++; if (instr_pc_o !== 10'h000) $display("FAIL ares_first_pc got=%h exp=000", instr_pc_o); else n_pass++;
        n_total++; if (instr_o !== 32'h1000_0000) $display("FAIL ares_first_data got=%h exp=10000000", instr_o); else n_pass++;
    endtask

    initial begin
        rst_ni          = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        instr_ready_i   = 1'b0;
        mem_dout_i      = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_bypass();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch_buffer.md
# ifetch_prefetch_buffer

Instruction prefetch buffer between `instr_memory` (synchronous read, 1-cycle latency) and the CPU fetch stage. It runs a sequential fetch PC ahead of the core and issues one word read per cycle while credit allows. Returned words are queued in a small FIFO and presented to fetch with a valid/ready handshake. A redirect (branch/jump/exception) flushes the queue, discards the in-flight read and restarts fetch at a new address.

## Interface
- `ADDR_W`, 10: byte-address width; matches `instr_memory` `ram_add`.
- `DATA_W`, 32: instruction width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_ADDR`, 0: first fetch address after reset; word aligned.

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `redirect_i`  in  1  flush and restart fetch.
- `redirect_addr_i`  in  ADDR_W  restart byte address; bits [1:0] ignored (forced 0).
- `mem_en_o`  out  1  read enable to `instr_memory` `en_i`.
- `mem_addr_o`  out  ADDR_W  byte address to `instr_memory` `addr_i`.
- `mem_dout_i`  in  DATA_W  `instr_memory` `dout_o`; valid the cycle after `mem_en_o`.
- `instr_valid_o`  out  1  head instruction available.
- `instr_o`  out  DATA_W  head instruction.
- `instr_pc_o`  out  ADDR_W  byte address of `instr_o`.
- `instr_ready_i`  in  1  fetch accepts head; transfer = valid & ready.
- `count_o`  out  clog2(DEPTH+1)  FIFO occupancy.

## Operation
- State: `pf_pc`, `inflight` flag plus its address `inflight_pc`, FIFO (data and pc per entry), read/write pointers, count.
- Issue rule: `mem_en_o = redirect_i | (count + inflight < DEPTH)`. Pop lookahead is not used.
- `mem_addr_o = redirect_i ? {redirect_addr_i[ADDR_W-1:2],2'b00} : pf_pc`. On each issue, `pf_pc` becomes issued address + 4, modulo 2^ADDR_W (0x3FC wraps to 0x000).
- Return: when `inflight` is set, `mem_dout_i`/`inflight_pc` are pushed into the FIFO. The credit rule guarantees space, so no push at full ever occurs.
- `instr_valid_o = (count != 0) & ~redirect_i`. A pop occurs on valid & ready.
- Redirect priority:
  - Same cycle: count, pointers and the pending return are cleared. The in-flight word returning this cycle is dropped, not pushed. No pop occurs.
  - The redirect read is issued and `inflight` is set for it.
- Simultaneous push and pop: both occur and count is unchanged.
- Empty with ready: valid stays low; no underflow.
- Reset values: `pf_pc = RESET_ADDR`, `inflight = 0`, count 0, pointers 0. Outputs are `mem_en_o = 0`, `instr_valid_o = 0`, `count_o = 0`, `instr_o = 0`, `instr_pc_o = 0`. Reset mid-operation discards everything; memory data arriving after release is ignored.

## Timing
- First issue: the first rising edge with `rst_ni` high. `mem_en_o` is high during that cycle (C0) with address `RESET_ADDR`.
- Fetch latency, issue cycle N:
  - Data at N+1, pushed at the end of N+1.
  - `instr_valid_o` at N+2 (N+1 with bypass; see Configuration).
- Steady-state throughput: 1 instruction/cycle with `instr_ready_i` held high.
- Combinational paths:
  - `redirect_i` → `instr_valid_o`, `mem_en_o`, `mem_addr_o`.
  - With bypass only: `mem_dout_i` → `instr_o`.
- Async reset: outputs go to reset values without waiting for a clock edge.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - When `inflight` is set, the FIFO is empty and `redirect_i` is low, the returning word is presented directly. `instr_valid_o = 1`, `instr_o = mem_dout_i`, `instr_pc_o = inflight_pc`.
  - If `instr_ready_i` is high, the word is consumed and not pushed; otherwise it is pushed.
  - Latency after issue/redirect is 1 cycle.
- `IFETCH_BYPASS_EN` undefined: every word passes through the FIFO; latency 2 cycles; no `mem_dout_i` → output path.

## Test plan
- Reset release, ready=1, memory word k = 0x10000000+k: `mem_en_o` every cycle from C0. `instr_valid_o` from C2 with pc 0x000, 0x004, 0x008… and data 0x10000000, 0x10000001…, one per cycle, no gaps.
- ready=0 from reset: exactly 4 issues (0x000–0x00C), then `mem_en_o` stays 0. `count_o` reaches 4 and holds. Raising ready drains 0x000–0x00C in order, fetch resumes at 0x010, no loss or duplication.
- Redirect to 0x040 with count=3 and one read in flight: valid low that cycle; next cycle count=0 and the old in-flight word is absent. First new instruction has pc 0x040, 2 cycles after redirect.
- Wrap: redirect to 0x3FE → issued address 0x3FC. Delivered pcs are 0x3FC then 0x000.
- Bypass: redirect at N with FIFO empty, ready=1. With `IFETCH_BYPASS_EN`, valid at N+1 and `count_o` stays 0; without it, valid at N+2.
- `rst_ni` pulsed low mid-stream between clock edges: `instr_valid_o`, `mem_en_o` and `count_o` are 0 immediately. After release, fetch restarts at `RESET_ADDR`.
